timer_ctrl_master: RTL



---
 rtl/timer_ctrl_pkg.sv | 74 +++++++
 rtl/timer_ctrl_bus_drv.sv | 56 +++++
 rtl/timer_ctrl_master.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval-timer control master: slave register
// map, control/status bit positions and the sequencing FSM states.
// Optional feature macro: TIMER_CTRL_SNAPSHOT_EN (adds snapshot states).
package timer_ctrl_pkg;

  // Interval-timer slave register map (16-bit word addresses)
  localparam logic [3:0] ADDR_STATUS  = 4'd0;
  localparam logic [3:0] ADDR_CONTROL = 4'd1;
  localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
  localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
  localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
  localparam logic [3:0] ADDR_PERIOD3 = 4'd5;
  localparam logic [3:0] ADDR_SNAP0   = 4'd6;
  localparam logic [3:0] ADDR_SNAP1   = 4'd7;
  localparam logic [3:0] ADDR_SNAP2   = 4'd8;
  localparam logic [3:0] ADDR_SNAP3   = 4'd9;

  // Status register: bit0 TO (timeout), bit1 RUN
  localparam int STATUS_TO = 0;

  // Control register bit positions
  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;

  typedef enum logic [4:0] {
    S_IDLE,
    S_W_STOP,
    S_W_P0,
    S_W_P1,
    S_W_P2,
    S_W_P3,
    S_W_CLR,
    S_W_START,
    S_WAIT,
    S_R_ISSUE,
    S_R_SAMPLE,
    S_ACK,
    S_W_ABORT,
    S_W_ABCLR
`ifdef TIMER_CTRL_SNAPSHOT_EN
    ,
    S_W_SNAP,
    S_SN_ISSUE,
    S_SN_SAMPLE
`endif
  } state_t;

  // Assemble a control-register word from its individual bits.
  function automatic logic [15:0] ctrl_word(input logic ito, input logic cont,
                                            input logic start, input logic stop);
    logic [15:0] w;
    w             = '0;
    w[CTRL_ITO]   = ito;
    w[CTRL_CONT]  = cont;
    w[CTRL_START] = start;
    w[CTRL_STOP]  = stop;
    return w;
  endfunction

  // Snapshot halfword address, least significant halfword first.
  function automatic logic [3:0] snap_addr(input logic [1:0] idx);
    logic [3:0] a;
    case (idx)
      2'd0:    a = ADDR_SNAP0;
      2'd1:    a = ADDR_SNAP1;
      2'd2:    a = ADDR_SNAP2;
      default: a = ADDR_SNAP3;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/timer_ctrl_bus_drv.sv
// Avalon-MM bus driver for the timer slave. A one-cycle op request becomes a
// single-cycle write, or a read strobe followed by a hold cycle in which the
// registered slave read data is returned on rd_valid/rd_data.
module timer_ctrl_bus_drv (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  input  logic        op_write,
  input  logic [3:0]  op_addr,
  input  logic [15:0] op_data,
  output logic [3:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  output logic        rd_valid,
  output logic [15:0] rd_data
);

  logic       rd_pend;
  logic [3:0] rd_addr;

  // Remember an issued read so its address is held during the sample cycle
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_pend <= op_valid && !op_write;
      if (op_valid && !op_write) rd_addr <= op_addr;
    end
  end

  // Drive the bus: a new op wins; otherwise hold a read address or go idle
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    m_address    = '0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    if (op_valid) begin
      m_address    = op_addr;
      m_chipselect = 1'b1;
      m_write_n    = !op_write;
      m_writedata  = op_write ? op_data : 16'h0000;
    end else if (rd_pend) begin
      m_address = rd_addr;
    end
  end

  assign rd_valid = rd_pend;
  assign rd_data  = m_readdata;

endmodule

// File: rtl/timer_ctrl_master.sv
// Hardware Avalon-MM initiator for the 16-bit interval-timer slave: programs
// the 64-bit period, starts the timer, detects timeouts via irq or status
// polling, acknowledges each one and reports a pulse plus saturating count.
// Optional feature macro: TIMER_CTRL_SNAPSHOT_EN (counter snapshot readout).
module timer_ctrl_master
  import timer_ctrl_pkg::*;
#(
  parameter int POLL_INTERVAL = 16,
  parameter int TO_CNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [63:0]         cmd_period,
  input  logic                cmd_continuous,
  input  logic                cmd_use_irq,
  input  logic                stop_req,
  output logic [3:0]          m_address,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [15:0]         m_writedata,
  input  logic [15:0]         m_readdata,
  input  logic                m_irq,
  output logic                busy,
  output logic                timeout_pulse,
  output logic [TO_CNT_W-1:0] timeout_count
`ifdef TIMER_CTRL_SNAPSHOT_EN
  ,
  input  logic                snap_req,
  output logic [63:0]         snap_value,
  output logic                snap_valid
`endif
);

  localparam int PW = $clog2(POLL_INTERVAL + 1);

  state_t        state, nxt;
  logic          ready_q;
  logic [63:0]   period_q;
  logic          cont_q;
  logic          irq_q;
  logic [PW-1:0] poll_cnt;
  logic          first_wait;
  logic          op_valid, op_write;
  logic [3:0]    op_addr;
  logic [15:0]   op_data;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic          accept, irq_hit, poll_done, status_to;

`ifdef TIMER_CTRL_SNAPSHOT_EN
  logic [1:0]    snap_idx;
`else
  // Only the TO bit of a read is consumed when snapshots are not built in
  logic          rd_unused;
  assign rd_unused = ^rd_data[15:1];
`endif

  assign accept    = (state == S_IDLE) && cmd_valid && ready_q;
  // irq is ignored in the first WAIT cycle after an ACK while the slave drops it
  assign irq_hit   = irq_q && m_irq && !first_wait;
  assign poll_done = !irq_q && (poll_cnt == PW'(POLL_INTERVAL - 1));
  assign status_to = rd_valid && rd_data[STATUS_TO];

  assign cmd_ready     = ready_q && (state == S_IDLE);
  assign busy          = (state != S_IDLE);
  assign timeout_pulse = (state == S_ACK);

  timer_ctrl_bus_drv u_bus_drv (
    .clk          (clk),
    .reset_n      (reset_n),
    .op_valid     (op_valid),
    .op_write     (op_write),
    .op_addr      (op_addr),
    .op_data      (op_data),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write_n    (m_write_n),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= nxt;
  end

  // Next-state decode and per-state bus op request
  always_comb begin
    nxt      = state;
    op_valid = 1'b0;
    op_write = 1'b1;
    op_addr  = ADDR_STATUS;
    op_data  = '0;
    case (state)
      S_IDLE:     if (accept) nxt = S_W_STOP;
      S_W_STOP: begin
        op_valid = 1'b1;
        op_addr  = ADDR_CONTROL;
        op_data  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        nxt      = S_W_P0;
      end
      S_W_P0: begin
        op_valid = 1'b1;
        op_addr  = ADDR_PERIOD0;
        op_data  = period_q[15:0];
        nxt      = S_W_P1;
      end
      S_W_P1: begin
        op_valid = 1'b1;
        op_addr  = ADDR_PERIOD1;
        op_data  = period_q[31:16];
        nxt      = S_W_P2;
      end
      S_W_P2: begin
        op_valid = 1'b1;
        op_addr  = ADDR_PERIOD2;
        op_data  = period_q[47:32];
        nxt      = S_W_P3;
      end
      S_W_P3: begin
        op_valid = 1'b1;
        op_addr  = ADDR_PERIOD3;
        op_data  = period_q[63:48];
        nxt      = S_W_CLR;
      end
      S_W_CLR: begin
        op_valid = 1'b1;
        nxt      = S_W_START;
      end
      S_W_START: begin
        op_valid = 1'b1;
        op_addr  = ADDR_CONTROL;
        op_data  = ctrl_word(irq_q, cont_q, 1'b1, 1'b0);
        nxt      = S_WAIT;
      end
      S_WAIT: begin
        // A detected timeout beats stop_req; stop beats a due poll or snapshot
        if (irq_hit)        nxt = S_ACK;
        else if (stop_req)  nxt = S_W_ABORT;
        else if (poll_done) nxt = S_R_ISSUE;
`ifdef TIMER_CTRL_SNAPSHOT_EN
        else if (snap_req)  nxt = S_W_SNAP;
`endif
      end
      S_R_ISSUE: begin
        op_valid = 1'b1;
        op_write = 1'b0;
        nxt      = stop_req ? S_W_ABORT : S_R_SAMPLE;
      end
      S_R_SAMPLE: begin
        if (status_to)     nxt = S_ACK;
        else if (stop_req) nxt = S_W_ABORT;
        else               nxt = S_WAIT;
      end
      S_ACK: begin
        op_valid = 1'b1;
        nxt      = cont_q ? S_WAIT : S_IDLE;
      end
      S_W_ABORT: begin
        op_valid = 1'b1;
        op_addr  = ADDR_CONTROL;
        op_data  = ctrl_word(1'b0, 1'b0, 1'b0, 1'b1);
        nxt      = S_W_ABCLR;
      end
      S_W_ABCLR: begin
        op_valid = 1'b1;
        nxt      = S_IDLE;
      end
`ifdef TIMER_CTRL_SNAPSHOT_EN
      S_W_SNAP: begin
        op_valid = 1'b1;
        op_addr  = ADDR_SNAP0;
        nxt      = S_SN_ISSUE;
      end
      S_SN_ISSUE: begin
        op_valid = 1'b1;
        op_write = 1'b0;
        op_addr  = snap_addr(snap_idx);
        nxt      = S_SN_SAMPLE;
      end
      S_SN_SAMPLE: nxt = (snap_idx == 2'd3) ? S_WAIT : S_SN_ISSUE;
`endif
      default:    nxt = S_IDLE;
    endcase
  end

  // Command latch, timeout counting, poll timer and post-ACK irq mask
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ready_q       <= 1'b0;
      period_q      <= '0;
      cont_q        <= 1'b0;
      irq_q         <= 1'b0;
      timeout_count <= '0;
      poll_cnt      <= '0;
      first_wait    <= 1'b0;
    end else begin
      ready_q    <= 1'b1;
      first_wait <= (state == S_ACK);
      poll_cnt   <= (state == S_WAIT) ? poll_cnt + 1'b1 : '0;
      if (accept) begin
        period_q      <= cmd_period;
        cont_q        <= cmd_continuous;
        irq_q         <= cmd_use_irq;
        timeout_count <= '0;
      end else if (state == S_ACK && timeout_count != '1) begin
        timeout_count <= timeout_count + 1'b1;
      end
    end
  end

`ifdef TIMER_CTRL_SNAPSHOT_EN
  // Collect the four snapshot halfwords and flag completion for one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_idx   <= '0;
      snap_value <= '0;
      snap_valid <= 1'b0;
    end else begin
      snap_valid <= (state == S_SN_SAMPLE) && (snap_idx == 2'd3);
      if (state == S_W_SNAP) begin
        snap_idx <= '0;
      end else if (state == S_SN_SAMPLE) begin
        snap_value[16*snap_idx +: 16] <= rd_data;
        snap_idx                      <= snap_idx + 1'b1;
      end
    end
  end
`endif

endmodule
